// File: rtl/int_controller.sv
// rtl/int_controller.sv - interrupt request/vector generator with periodic timer and edge-detected device lines
module int_controller #(
  parameter int NUM_SRC = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cfg_wr,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_data,
  input  logic [NUM_SRC-1:0] op_req,
  input  logic               int_ack,
  input  logic               int_eoi,
  output logic               timer_int,
  output logic               op_int,
  output logic [15:0]        int_pos,
  output logic [15:0]        sys_int_pos,
  output logic [3:0]         int_cause,
  output logic               busy,
  output logic               timer_overrun
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] ACTIVE  = 2'd2;

  logic [1:0]         state;
  logic [31:0]        period;
  logic [31:0]        timer_cnt;
  logic [15:0]        timer_vec;
  logic [15:0]        op_base;
  logic [15:0]        sys_vec;
  logic               timer_pend;
  logic [NUM_SRC-1:0] op_prev;
  logic [NUM_SRC-1:0] op_pend;
  logic               svc_timer;
  logic [2:0]         svc_idx;

  logic               period_wr;
  logic               tick;
  logic               ack_fire;
  logic               clr_timer;
  logic [NUM_SRC-1:0] op_clr;
  logic [NUM_SRC-1:0] op_set;
  logic               any_op;
  logic [2:0]         sel_idx;

  assign period_wr   = cfg_wr && (cfg_addr == 2'd0);
  assign tick        = !period_wr && (period != 32'd0) && (timer_cnt == 32'd1);
  assign ack_fire    = (state == PENDING) && int_ack;
  assign clr_timer   = ack_fire && svc_timer;
  assign op_set      = op_req & ~op_prev;
  assign any_op      = |op_pend;
  assign sys_int_pos = sys_vec;
  assign busy        = (state != IDLE);

  // Decode the pending bit released by an ack and pick the lowest pending device
  always_comb begin
    op_clr  = '0;
    sel_idx = 3'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ack_fire && !svc_timer && (svc_idx == i[2:0])) op_clr[i] = 1'b1;
    end
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (op_pend[i]) sel_idx = i[2:0];
    end
  end

  // Configuration registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period    <= 32'd0;
      timer_vec <= 16'd0;
      op_base   <= 16'd0;
      sys_vec   <= 16'd0;
    end else if (cfg_wr) begin
      case (cfg_addr)
        2'd0: period    <= cfg_data;
        2'd1: timer_vec <= cfg_data[15:0];
        2'd2: op_base   <= cfg_data[15:0];
        default: sys_vec <= cfg_data[15:0];
      endcase
    end
  end

  // Periodic down-counter; a period write restarts it and clears the overrun flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_cnt     <= 32'd0;
      timer_overrun <= 1'b0;
    end else if (period_wr) begin
      timer_cnt     <= cfg_data;
      timer_overrun <= 1'b0;
    end else begin
      if (period == 32'd0)        timer_cnt <= 32'd0;
      else if (timer_cnt == 32'd1) timer_cnt <= period;
      else                         timer_cnt <= timer_cnt - 32'd1;
      if (tick && timer_pend && !clr_timer) timer_overrun <= 1'b1;
    end
  end

  // Pending bits: a new set in the same edge as a clear keeps the bit high
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_pend <= 1'b0;
      op_prev    <= '0;
      op_pend    <= '0;
    end else begin
      timer_pend <= tick | (timer_pend & ~clr_timer);
      op_prev    <= op_req;
      op_pend    <= op_set | (op_pend & ~op_clr);
    end
  end

  // Single-level service FSM; request outputs are latched on entry to PENDING
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer_int <= 1'b0;
      op_int    <= 1'b0;
      int_pos   <= 16'd0;
      int_cause <= 4'd0;
      svc_timer <= 1'b0;
      svc_idx   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (timer_pend) begin
            state     <= PENDING;
            timer_int <= 1'b1;
            int_cause <= 4'h8;
            int_pos   <= timer_vec;
            svc_timer <= 1'b1;
          end else if (any_op) begin
            state     <= PENDING;
            op_int    <= 1'b1;
            int_cause <= {1'b0, sel_idx};
            int_pos   <= op_base + {13'd0, sel_idx};
            svc_timer <= 1'b0;
            svc_idx   <= sel_idx;
          end
        end
        PENDING: begin
          if (int_ack) begin
            state     <= ACTIVE;
            timer_int <= 1'b0;
            op_int    <= 1'b0;
            int_pos   <= 16'd0;
            int_cause <= 4'd0;
          end
        end
        ACTIVE: begin
          if (int_eoi) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// tb/tb_int_controller.sv - directed-vector bench for int_controller
module tb_int_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_data = 32'd0;
  logic [3:0]  op_req = 4'd0;
  logic        int_ack = 1'b0;
  logic        int_eoi = 1'b0;
  logic        timer_int;
  logic        op_int;
  logic [15:0] int_pos;
  logic [15:0] sys_int_pos;
  logic [3:0]  int_cause;
  logic        busy;
  logic        timer_overrun;

  int n_vec = 0;
  int n_err = 0;

  int_controller #(.NUM_SRC(4)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .cfg_wr(cfg_wr),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .op_req(op_req),
    .int_ack(int_ack),
    .int_eoi(int_eoi),
    .timer_int(timer_int),
    .op_int(op_int),
    .int_pos(int_pos),
    .sys_int_pos(sys_int_pos),
    .int_cause(int_cause),
    .busy(busy),
    .timer_overrun(timer_overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
    step(1);
    cfg_wr = 1'b0;
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1; step(1); int_ack = 1'b0;
  endtask

  task automatic eoi_pulse();
    int_eoi = 1'b1; step(1); int_eoi = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tint"}, 32'(timer_int), 32'd0);
    check({tag, "_oint"}, 32'(op_int), 32'd0);
    check({tag, "_pos"}, 32'(int_pos), 32'd0);
    check({tag, "_sys"}, 32'(sys_int_pos), 32'd0);
    check({tag, "_cause"}, 32'(int_cause), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ovr"}, 32'(timer_overrun), 32'd0);
  endtask

  initial begin
    #3;
    check_all_zero("rst");
    step(1);
    reset_n = 1'b1;
    step(1);

    // Timer: period 5, no acks, then overrun
    cfg_write(2'd1, 32'h0040);
    cfg_write(2'd0, 32'd5);                 // edge 0
    step(4);                                // edge 4
    check("t_pend_e4", 32'(dut.timer_pend), 32'd0);
    step(1);                                // edge 5
    check("t_pend_e5", 32'(dut.timer_pend), 32'd1);
    check("t_int_e5", 32'(timer_int), 32'd0);
    step(1);                                // edge 6
    check("t_int_e6", 32'(timer_int), 32'd1);
    check("t_cause", 32'(int_cause), 32'h8);
    check("t_pos", 32'(int_pos), 32'h0040);
    check("t_busy", 32'(busy), 32'd1);
    cfg_write(2'd1, 32'h0077);              // edge 7
    check("t_pos_locked", 32'(int_pos), 32'h0040);
    eoi_pulse();                            // edge 8
    check("eoi_in_pend_busy", 32'(busy), 32'd1);
    check("eoi_in_pend_tint", 32'(timer_int), 32'd1);
    step(1);                                // edge 9
    check("ovr_e9", 32'(timer_overrun), 32'd0);
    step(1);                                // edge 10
    check("ovr_e10", 32'(timer_overrun), 32'd1);
    cfg_write(2'd0, 32'd0);
    check("ovr_clr", 32'(timer_overrun), 32'd0);
    ack_pulse();
    check("t_ack_tint", 32'(timer_int), 32'd0);
    check("t_ack_pos", 32'(int_pos), 32'd0);
    check("t_ack_cause", 32'(int_cause), 32'd0);
    check("t_ack_busy", 32'(busy), 32'd1);
    eoi_pulse();
    check("t_eoi_busy", 32'(busy), 32'd0);
    step(2);
    check("t_idle_quiet", 32'(busy), 32'd0);
    cfg_write(2'd3, 32'h0000_1234);
    check("sys_pos", 32'(sys_int_pos), 32'h1234);
    ack_pulse();
    check("ack_in_idle", 32'(busy), 32'd0);

    // Devices 1 and 2 raised together
    cfg_write(2'd2, 32'h0100);
    op_req = 4'b0110;
    step(1);
    check("op_e1_int", 32'(op_int), 32'd0);
    step(1);
    check("op_int_a", 32'(op_int), 32'd1);
    check("op_cause_a", 32'(int_cause), 32'd1);
    check("op_pos_a", 32'(int_pos), 32'h0101);
    ack_pulse();
    check("op_ack", 32'(op_int), 32'd0);
    eoi_pulse();
    check("op_eoi_busy", 32'(busy), 32'd0);
    step(1);
    check("op_int_b", 32'(op_int), 32'd1);
    check("op_cause_b", 32'(int_cause), 32'd2);
    check("op_pos_b", 32'(int_pos), 32'h0102);
    ack_pulse();
    eoi_pulse();
    step(2);
    check("op_level_once", 32'(busy), 32'd0);
    op_req = 4'b0000;
    step(1);

    // Timer tick and device 0 edge on the same edge
    cfg_write(2'd0, 32'd3);                 // edge 0
    step(2);                                // edge 2
    op_req = 4'b0001;
    step(1);                                // edge 3: both pending
    step(1);                                // edge 4
    check("pri_tint", 32'(timer_int), 32'd1);
    check("pri_oint", 32'(op_int), 32'd0);
    check("pri_cause", 32'(int_cause), 32'h8);
    cfg_write(2'd0, 32'd0);                 // edge 5: stop timer
    ack_pulse();
    eoi_pulse();
    step(1);
    check("pri_dev_int", 32'(op_int), 32'd1);
    check("pri_dev_cause", 32'(int_cause), 32'd0);
    check("pri_dev_pos", 32'(int_pos), 32'h0100);
    ack_pulse();
    eoi_pulse();
    op_req = 4'b0000;
    step(1);

    // Vector wrap
    cfg_write(2'd2, 32'hFFFE);
    op_req = 4'b1000;
    step(2);
    check("wrap_cause", 32'(int_cause), 32'd3);
    check("wrap_pos", 32'(int_pos), 32'h0001);
    ack_pulse();
    eoi_pulse();
    op_req = 4'b0000;
    step(1);

    // Reset while ACTIVE with device 1 still pending
    op_req = 4'b0011;
    step(2);
    check("pre_rst_cause", 32'(int_cause), 32'd0);
    ack_pulse();
    check("pre_rst_busy", 32'(busy), 32'd1);
    #3;
    reset_n = 1'b0;
    op_req = 4'b0000;
    #1;
    check_all_zero("async_rst");
    step(1);
    reset_n = 1'b1;
    step(3);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_oint", 32'(op_int), 32'd0);
    op_req = 4'b0100;
    step(2);
    check("post_rst_new_int", 32'(op_int), 32'd1);
    check("post_rst_new_pos", 32'(int_pos), 32'h0002);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/int_controller.md
# int_controller

Interrupt source for the core's program counter. Generates the `timer_int`/`op_int` requests and the `int_pos`/`sys_int_pos` handler vectors that the program counter consumes. Holds a request until the core acknowledges it, then masks further requests until end-of-interrupt. Contains a programmable periodic timer, edge-detected device requests, a vector table and a single-level service state machine.

## Interface
- `NUM_SRC`, 4, number of device request lines; legal range 1..8.
- `clock`  in  1  system clock; all state updates on posedge, so outputs are stable at the program counter's negedge sample.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cfg_wr`  in  1  configuration write strobe.
- `cfg_addr`  in  2  configuration register select:
  - 0: timer period
  - 1: timer vector
  - 2: op vector base
  - 3: syscall vector
- `cfg_data`  in  32  write data; vectors use [15:0].
- `op_req`  in  NUM_SRC  device request lines, synchronous to `clock`.
- `int_ack`  in  1  core took the interrupt. One-cycle pulse.
- `int_eoi`  in  1  handler finished. One-cycle pulse.
- `timer_int`  out  1  timer interrupt request.
- `op_int`  out  1  device interrupt request.
- `int_pos`  out  16  handler address for the current request.
- `sys_int_pos`  out  16  syscall entry address; equals the syscall vector register.
- `int_cause`  out  4  4'h8 = timer, 4'h0..7 = device index; 0 when not pending.
- `busy`  out  1  state != IDLE.
- `timer_overrun`  out  1  sticky flag: a timer tick was lost.

## Operation
- Reset (asynchronous, any state):
  - all registers, counters and pending bits clear to 0;
  - state goes to IDLE;
  - every output is 0.
- Config writes take effect at the edge where `cfg_wr` is high. A period write also loads `timer_cnt` = `cfg_data` and clears `timer_overrun`.
- Timer:
  - A period of 0 disables the timer: the counter is held at 0 and no ticks occur.
  - Otherwise, at each edge: if `timer_cnt`==1, tick and reload `timer_cnt` = period; else decrement.
  - A tick sets `timer_pend`. If a tick arrives while `timer_pend` is already 1 and not being cleared that edge, set `timer_overrun`.
- Device requests:
  - `op_prev` registers `op_req` every edge.
  - `op_pend[i]` is set when `op_req[i]` is high and `op_prev[i]` is low.
  - A level held high produces one request only.
- State machine:
  - **IDLE**
    - If `timer_pend`: go to PENDING with `int_cause`=8, `int_pos`=timer vector, `timer_int`=1.
    - Else if any `op_pend`: take the lowest set index i and go to PENDING with `int_cause`=i, `int_pos`=op base + i, `op_int`=1. The sum is 16-bit and wraps modulo 2^16.
    - Timer has priority over devices.
  - **PENDING**
    - Outputs are latched at entry and unaffected by later config writes.
    - On `int_ack`:
      - clear the serviced pending bit;
      - drop `timer_int`/`op_int` to 0 and `int_pos`/`int_cause` to 0;
      - go to ACTIVE.
  - **ACTIVE**
    - New requests accumulate in their pending bits but are not presented.
    - On `int_eoi`: go to IDLE.
- Ignored inputs:
  - `int_ack` outside PENDING is ignored.
  - `int_eoi` outside ACTIVE is ignored.
- Simultaneous clear and set of the same pending bit: set wins, the bit stays 1, and no overrun is recorded.

## Timing
- Timer latency:
  - A period P write at edge 0 gives the first tick at edge P, so `timer_pend` is high after edge P.
  - `timer_int` rises after edge P+1 if the state was IDLE.
  - Ticks then repeat every P edges.
- Device latency: `op_req` rising before edge 1 gives `op_pend` after edge 1 and `op_int` after edge 2.
- Handshake:
  - An ack sampled at edge k drops the request outputs after edge k.
  - An eoi at edge m returns the block to IDLE after edge m.
  - The earliest next request appears after edge m+1.
- Back-to-back: the minimum cycle from one request to the next request is 3 edges (ack, eoi, IDLE→PENDING).

## Test plan
- Reset, write period 5, no acks:
  - `timer_pend` high after edge 5 and `timer_int` high after edge 6;
  - tick at edge 10 sets `timer_overrun`=1;
  - a period write clears it.
- Op vector base 0x0100, raise `op_req`=4'b0110 together:
  - `op_int`=1, `int_cause`=1, `int_pos`=0x0101;
  - after ack and eoi, `int_cause`=2, `int_pos`=0x0102.
- Timer tick and `op_req[0]` edge on the same cycle: timer is served first (`int_cause`=8); the device is served after eoi.
- Op base 0xFFFE and `op_req[3]` edge: `int_pos`=0x0001 (wrap).
- Ignored handshakes:
  - `int_ack` in IDLE and `int_eoi` in PENDING leave the state unchanged;
  - a `cfg_wr` to the timer vector during PENDING leaves `int_pos` unchanged.
- Assert `reset_n`=0 mid-ACTIVE with pending bits set: all outputs are 0 immediately, and no request appears after reset until a new tick or edge.
